// File: rtl/fft_ctrl_pkg.sv
// Shared state encoding and default geometry for the FFT sequencing controller.
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    LOAD_EXT,
    CALC,
    CALC_DONE,
    DRAIN,
    WAIT_OUT,
    DONE
  } seq_state_t;

  localparam int unsigned DEF_STAGES      = 10;
  localparam int unsigned DEF_CYC_PER_STG = 512;
  localparam int unsigned DEF_OUT_BEATS   = 1024;

endpackage

// File: rtl/fft_stage_counter.sv
// Nested stage/cycle counter for the butterfly sweep; both fields wrap to zero
// together after the last cycle of the last stage.
module fft_stage_counter #(
  parameter int unsigned STAGES      = 10,
  parameter int unsigned CYC_PER_STG = 512,
  parameter int unsigned STG_W       = 5,
  parameter int unsigned CYC_W       = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [STG_W-1:0] stageCount,
  output logic [CYC_W-1:0] cycleCount,
  output logic             last
);

  localparam logic [STG_W-1:0] LAST_STG = STG_W'(STAGES - 1);
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CYC_PER_STG - 1);

  logic cycWrap;

  always_comb begin
    cycWrap = (cycleCount == LAST_CYC);
    last    = cycWrap && (stageCount == LAST_STG);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stageCount <= '0;
      cycleCount <= '0;
    end else if (en) begin
      if (cycWrap) begin
        cycleCount <= '0;
        stageCount <= last ? '0 : stageCount + 1'b1;
      end else begin
        cycleCount <= cycleCount + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_seq_ctrl.sv
// Job sequencer for the FFT accelerator: load, stage sweep, drain, done.
// Optional busy-cycle counter port enabled by FFT_SEQ_CTRL_PERF_EN.
module fft_seq_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int unsigned STAGES      = DEF_STAGES,
  parameter int unsigned CYC_PER_STG = DEF_CYC_PER_STG,
  parameter int unsigned OUT_BEATS   = DEF_OUT_BEATS,
  parameter int unsigned SIG_W       = 18,
  parameter int unsigned STG_W       = 5,
  parameter int unsigned CYC_W       = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startF,
  input  logic             startI,
  input  logic             filter,
  input  logic [SIG_W-1:0] sigNum,
  input  logic             inFifoReady,
  input  logic             loadExternalDone,
  input  logic             outFifoReady,
  output logic             calculating,
  output logic             done,
  output logic [SIG_W-1:0] sigNumMC,
  output logic             isIFFT,
  output logic             filterActive,
  output logic             loadExternal,
  output logic             loadInternal,
  output logic [STG_W-1:0] stageCount,
  output logic [CYC_W-1:0] cycleCount,
  output logic             doneCalculating,
`ifdef FFT_SEQ_CTRL_PERF_EN
  output logic [31:0]      busyCycles,
`endif
  output logic             loadOutBuffer
);

  localparam int unsigned     BEAT_W    = $clog2(OUT_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(OUT_BEATS - 1);

  seq_state_t        state, nextState;
  logic [BEAT_W-1:0] beatCnt;
  logic              calcLast;
  logic              accept;

  assign accept = (state == IDLE) && (startF || startI);

  fft_stage_counter #(
    .STAGES      (STAGES),
    .CYC_PER_STG (CYC_PER_STG),
    .STG_W       (STG_W),
    .CYC_W       (CYC_W)
  ) u_stageCounter (
    .clk        (clk),
    .rst        (rst),
    .en         (state == CALC),
    .clr        (state != CALC),
    .stageCount (stageCount),
    .cycleCount (cycleCount),
    .last       (calcLast)
  );

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:      if (startF || startI)         nextState = WAIT_IN;
      WAIT_IN:   if (inFifoReady)              nextState = LOAD_EXT;
      LOAD_EXT:  if (loadExternalDone)         nextState = CALC;
      CALC:      if (calcLast)                 nextState = CALC_DONE;
      CALC_DONE:                               nextState = DRAIN;
      DRAIN:     if (beatCnt == LAST_BEAT)     nextState = WAIT_OUT;
      WAIT_OUT:  if (outFifoReady)             nextState = DONE;
      DONE:                                    nextState = IDLE;
      default:                                 nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (rst || state != DRAIN) beatCnt <= '0;
    else                       beatCnt <= beatCnt + 1'b1;
  end

  // Strobes are decoded from nextState so each lines up with its state cycle from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      calculating     <= 1'b0;
      done            <= 1'b0;
      loadExternal    <= 1'b0;
      loadInternal    <= 1'b0;
      doneCalculating <= 1'b0;
      loadOutBuffer   <= 1'b0;
      sigNumMC        <= '0;
      isIFFT          <= 1'b0;
      filterActive    <= 1'b0;
    end else begin
      calculating     <= (nextState != IDLE) && (nextState != DONE);
      done            <= (nextState == DONE);
      loadExternal    <= (nextState == LOAD_EXT);
      loadInternal    <= (nextState == CALC);
      doneCalculating <= (nextState == CALC_DONE);
      loadOutBuffer   <= (nextState == DRAIN);
      if (accept) begin
        sigNumMC     <= sigNum;
        isIFFT       <= ~startF;
        filterActive <= filter;
      end
    end
  end

`ifdef FFT_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      busyCycles <= '0;
    end else if (state == IDLE) begin
      if (accept) busyCycles <= '0;
    end else if (busyCycles != '1) begin
      busyCycles <= busyCycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scripted job sequences for fft_seq_ctrl; expected output words are queued as stimulus is driven.
module tb_fft_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, startF, startI, filter;
  logic [17:0] sigNum;
  logic        inFifoReady, loadExternalDone, outFifoReady;
  logic        calculating, done, isIFFT, filterActive;
  logic        loadExternal, loadInternal, doneCalculating, loadOutBuffer;
  logic [17:0] sigNumMC;
  logic [4:0]  stageCount;
  logic [8:0]  cycleCount;
`ifdef FFT_SEQ_CTRL_PERF_EN
  logic [31:0] busyCycles;
`endif

  int unsigned nCompared = 0;
  int unsigned nMismatch = 0;

  typedef struct {
    string       tag;
    logic [39:0] val;
  } exp_t;
  exp_t expQ[$];

  logic [17:0] exSig;
  logic        exIfft, exFilt;

  always #5 clk = ~clk;

  fft_seq_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .startF           (startF),
    .startI           (startI),
    .filter           (filter),
    .sigNum           (sigNum),
    .inFifoReady      (inFifoReady),
    .loadExternalDone (loadExternalDone),
    .outFifoReady     (outFifoReady),
    .calculating      (calculating),
    .done             (done),
    .sigNumMC         (sigNumMC),
    .isIFFT           (isIFFT),
    .filterActive     (filterActive),
    .loadExternal     (loadExternal),
    .loadInternal     (loadInternal),
    .stageCount       (stageCount),
    .cycleCount       (cycleCount),
    .doneCalculating  (doneCalculating),
`ifdef FFT_SEQ_CTRL_PERF_EN
    .busyCycles       (busyCycles),
`endif
    .loadOutBuffer    (loadOutBuffer)
  );

  task automatic checkVal(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    nCompared++;
    if (obs !== expv) begin
      nMismatch++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // {calc, done, ifft, filt, lExt, lInt, dCalc, lOut, stage, cycle, sig}
  function automatic logic [39:0] ex(input bit calc, input bit dn, input bit lext, input bit lint,
                                     input bit dcalc, input bit lout, input int stg, input int cyc);
    return {calc, dn, exIfft, exFilt, lext, lint, dcalc, lout, 5'(stg), 9'(cyc), exSig};
  endfunction

  task automatic step(input string tag, input logic [39:0] expv);
    exp_t e;
    expQ.push_back('{tag, expv});
    @(posedge clk);
    #1;
    e = expQ.pop_front();
    checkVal(e.tag, {calculating, done, isIFFT, filterActive, loadExternal, loadInternal,
                     doneCalculating, loadOutBuffer, stageCount, cycleCount, sigNumMC}, e.val);
  endtask

  task automatic runJob(input bit fwd, input bit inv, input bit filt, input logic [17:0] sig,
                        input int outWait, input bit pulseMid, input bit abortMid);
    step("idle", ex(0, 0, 0, 0, 0, 0, 0, 0));
    startF = fwd; startI = inv; filter = filt; sigNum = sig;
    exSig = sig; exIfft = !fwd; exFilt = filt;
    step("accept", ex(1, 0, 0, 0, 0, 0, 0, 0));
    startF = 0; startI = 0; filter = 0; sigNum = 18'($urandom);
    loadExternalDone = 1; outFifoReady = 1;
    step("waitIn", ex(1, 0, 0, 0, 0, 0, 0, 0));
    loadExternalDone = 0; outFifoReady = 0;
    step("waitIn", ex(1, 0, 0, 0, 0, 0, 0, 0));
    inFifoReady = 1;
    step("loadExt", ex(1, 0, 1, 0, 0, 0, 0, 0));
    inFifoReady = 0;
    step("loadExt", ex(1, 0, 1, 0, 0, 0, 0, 0));
    loadExternalDone = 1;
    step("calc0", ex(1, 0, 0, 1, 0, 0, 0, 0));
    loadExternalDone = 0;
    for (int idx = 1; idx < 10 * 512; idx++) begin
      if (abortMid && idx == 4 * 512 + 101) begin
        rst = 1;
        exSig = '0; exIfft = 0; exFilt = 0;
        step("midReset", ex(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 0;
        return;
      end
      startF = (pulseMid && idx == 2000);
      startI = (pulseMid && idx == 2001);
      step("calc", ex(1, 0, 0, 1, 0, 0, idx / 512, idx % 512));
    end
    startF = 0; startI = 0;
    step("calcDone", ex(1, 0, 0, 0, 1, 0, 0, 0));
    outFifoReady = (outWait == 0);
    for (int b = 0; b < 1024; b++)
      step("drain", ex(1, 0, 0, 0, 0, 1, 0, 0));
    step("waitOut", ex(1, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < outWait; k++)
      step("waitOut", ex(1, 0, 0, 0, 0, 0, 0, 0));
    outFifoReady = 1;
    step("done", ex(0, 1, 0, 0, 0, 0, 0, 0));
    outFifoReady = 0;
    step("idleHold", ex(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    rst = 1; startF = 0; startI = 0; filter = 0; sigNum = '0;
    inFifoReady = 0; loadExternalDone = 0; outFifoReady = 0;
    exSig = '0; exIfft = 0; exFilt = 0;
    #1;
    step("reset", ex(0, 0, 0, 0, 0, 0, 0, 0));
    step("reset", ex(0, 0, 0, 0, 0, 0, 0, 0));
    rst = 0;
    runJob(1, 0, 0, 18'h00001, 2, 0, 0);
    runJob(0, 1, 1, 18'h2ABCD, 0, 1, 0);
    runJob(1, 1, 1, 18'h15555, 0, 0, 1);
    runJob(1, 0, 0, 18'h00003, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
